// File: rtl/fu_alu_cluster_pkg.sv
// Shared types for the ALU cluster: operand selects, ALU/branch encodings, lane resolution flags.
package fu_alu_cluster_pkg;

  localparam int unsigned SHAMT_W = 6;

  typedef enum logic [1:0] {
    ALU_SEL_REG  = 2'd0,
    ALU_SEL_IMM  = 2'd1,
    ALU_SEL_PC   = 2'd2,
    ALU_SEL_ZERO = 2'd3
  } alu_sel_e;

  typedef enum logic [2:0] {
    ALU_ADD_SUB = 3'd0,
    ALU_SLL     = 3'd1,
    ALU_SLT     = 3'd2,
    ALU_SLTU    = 3'd3,
    ALU_XOR     = 3'd4,
    ALU_SRL_SRA = 3'd5,
    ALU_OR      = 3'd6,
    ALU_AND     = 3'd7
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_EQ  = 3'd0,
    BR_NE  = 3'd1,
    BR_LT  = 3'd4,
    BR_GE  = 3'd5,
    BR_LTU = 3'd6,
    BR_GEU = 3'd7
  } br_cond_e;

  // Control-flow resolution carried alongside each lane result
  typedef struct packed {
    logic taken;
    logic miss;
  } lane_cf_t;

endpackage

// File: rtl/fu_alu_cluster_lane.sv
// One ALU/branch lane: operand mux, ALU, branch compare, next-pc resolve and a
// single registered result stage with valid/ready handshakes.
module fu_alu_cluster_lane
  import fu_alu_cluster_pkg::*;
#(
  parameter int unsigned XLEN               = 64,
  parameter int unsigned PC_WIDTH           = 32,
  parameter int unsigned IMM_LEN            = 32,
  parameter int unsigned ROB_INDEX_WIDTH    = 4,
  parameter int unsigned PHY_REG_ADDR_WIDTH = 6
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          flush_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [XLEN-1:0]               rs1_i,
  input  logic [XLEN-1:0]               rs2_i,
  input  logic [IMM_LEN-1:0]            imm_i,
  input  logic [1:0]                    opr1_sel_i,
  input  logic [1:0]                    opr2_sel_i,
  input  logic [2:0]                    func3_i,
  input  logic                          func_mod_i,
  input  logic                          half_i,
  input  logic                          is_branch_i,
  input  logic                          is_jump_i,
  input  logic [PC_WIDTH-1:0]           pc_i,
  input  logic [PC_WIDTH-1:0]           next_pc_i,
  input  logic [PC_WIDTH-1:0]           predict_pc_i,
  input  logic [ROB_INDEX_WIDTH-1:0]    rob_index_i,
  input  logic [PHY_REG_ADDR_WIDTH-1:0] prd_addr_i,
  output logic                          resp_valid_o,
  input  logic                          resp_ready_i,
  output logic [ROB_INDEX_WIDTH-1:0]    wrb_rob_index_o,
  output logic [PHY_REG_ADDR_WIDTH-1:0] wrb_prd_addr_o,
  output logic [XLEN-1:0]               wrb_data_o,
  output logic                          branch_taken_o,
  output logic                          predict_miss_o,
  output logic [PC_WIDTH-1:0]           final_next_pc_o,
  output logic                          redirect_cand_c_o
);

  logic                          v_q, v_d;
  logic [ROB_INDEX_WIDTH-1:0]    rob_q;
  logic [PHY_REG_ADDR_WIDTH-1:0] prd_q;
  logic [XLEN-1:0]               data_q;
  logic [PC_WIDTH-1:0]           npc_q;
  lane_cf_t                      cf_q;

  logic                 req_fire, resp_fire;
  logic                 is_br;
  logic [XLEN-1:0]      opr1, opr2, alu_raw, alu_res, srl_src, sra_src, wrb_data;
  logic [SHAMT_W-1:0]   shamt;
  alu_op_e              op;
  logic                 sub;
  logic                 cond;
  logic [PC_WIDTH-1:0]  pc_sum, target, final_npc;
  lane_cf_t             cf;

  assign is_br       = is_branch_i & ~is_jump_i;
  assign req_ready_o = ~v_q | resp_ready_i;
  assign req_fire    = req_valid_i & req_ready_o & ~flush_i;
  assign resp_fire   = v_q & resp_ready_i;

  // Operand select; opr1 IMM yields zero so LUI/CSRxI reduce to 0 + imm
  always_comb begin
    opr1 = '0;
    opr2 = '0;
    case (alu_sel_e'(opr1_sel_i))
      ALU_SEL_REG: opr1 = rs1_i;
      ALU_SEL_PC:  opr1 = XLEN'(pc_i);
      default:     opr1 = '0;
    endcase
    case (alu_sel_e'(opr2_sel_i))
      ALU_SEL_REG: opr2 = rs2_i;
      ALU_SEL_IMM: opr2 = XLEN'($signed(imm_i));
      ALU_SEL_PC:  opr2 = XLEN'(pc_i);
      default:     opr2 = '0;
    endcase
  end

  assign op      = is_br ? ALU_ADD_SUB : alu_op_e'(func3_i);
  assign sub     = is_br ? 1'b0 : func_mod_i;
  assign shamt   = half_i ? {1'b0, opr2[4:0]} : opr2[SHAMT_W-1:0];
  assign srl_src = half_i ? XLEN'(opr1[31:0]) : opr1;
  assign sra_src = half_i ? XLEN'($signed(opr1[31:0])) : opr1;

  always_comb begin
    alu_raw = '0;
    case (op)
      ALU_ADD_SUB: alu_raw = sub ? (opr1 - opr2) : (opr1 + opr2);
      ALU_SLL:     alu_raw = opr1 << shamt;
      ALU_SLT:     alu_raw = XLEN'($signed(opr1) < $signed(opr2));
      ALU_SLTU:    alu_raw = XLEN'(opr1 < opr2);
      ALU_XOR:     alu_raw = opr1 ^ opr2;
      ALU_SRL_SRA: alu_raw = sub ? XLEN'($signed(sra_src) >>> shamt) : (srl_src >> shamt);
      ALU_OR:      alu_raw = opr1 | opr2;
      ALU_AND:     alu_raw = opr1 & opr2;
      default:     alu_raw = '0;
    endcase
  end

  assign alu_res = half_i ? XLEN'($signed(alu_raw[31:0])) : alu_raw;

  // Branch condition always compares the raw register sources
  always_comb begin
    cond = 1'b0;
    case (br_cond_e'(func3_i))
      BR_EQ:   cond = (rs1_i == rs2_i);
      BR_NE:   cond = (rs1_i != rs2_i);
      BR_LT:   cond = ($signed(rs1_i) < $signed(rs2_i));
      BR_GE:   cond = ($signed(rs1_i) >= $signed(rs2_i));
      BR_LTU:  cond = (rs1_i < rs2_i);
      BR_GEU:  cond = (rs1_i >= rs2_i);
      default: cond = 1'b0;
    endcase
  end

  assign pc_sum    = opr1[PC_WIDTH-1:0] + opr2[PC_WIDTH-1:0];
  assign target    = is_jump_i ? {pc_sum[PC_WIDTH-1:1], 1'b0} : pc_sum;
  assign cf.taken  = is_jump_i | (is_br & cond);
  assign final_npc = cf.taken ? target : next_pc_i;
  assign cf.miss   = (is_br | is_jump_i) & (final_npc != predict_pc_i);
  assign wrb_data  = is_jump_i ? XLEN'(next_pc_i) : alu_res;

  // Stage occupancy: flush wins, then a new issue, then drain on response
  always_comb begin
    v_d = v_q;
    if (flush_i)        v_d = 1'b0;
    else if (req_fire)  v_d = 1'b1;
    else if (resp_fire) v_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v_q    <= 1'b0;
      rob_q  <= '0;
      prd_q  <= '0;
      data_q <= '0;
      npc_q  <= '0;
      cf_q   <= '0;
    end else begin
      v_q <= v_d;
      if (req_fire) begin
        rob_q  <= rob_index_i;
        prd_q  <= prd_addr_i;
        data_q <= wrb_data;
        npc_q  <= final_npc;
        cf_q   <= cf;
      end
    end
  end

  assign resp_valid_o      = v_q;
  assign wrb_rob_index_o   = rob_q;
  assign wrb_prd_addr_o    = prd_q;
  assign wrb_data_o        = data_q;
  assign final_next_pc_o   = npc_q;
  assign branch_taken_o    = cf_q.taken;
  assign predict_miss_o    = cf_q.miss;
  assign redirect_cand_c_o = resp_fire & cf_q.miss;

endmodule

// File: rtl/fu_alu_cluster.sv
// NUM_ALU-lane ALU cluster with oldest-mispredict redirect arbitration.
// Optional perf counters are enabled by defining FU_PERF_CNT_EN.
module fu_alu_cluster
  import fu_alu_cluster_pkg::*;
#(
  parameter int unsigned NUM_ALU            = 2,
  parameter int unsigned XLEN               = 64,
  parameter int unsigned PC_WIDTH           = 32,
  parameter int unsigned IMM_LEN            = 32,
  parameter int unsigned ROB_INDEX_WIDTH    = 4,
  parameter int unsigned PHY_REG_ADDR_WIDTH = 6
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  flush_i,
  input  logic [ROB_INDEX_WIDTH-1:0]            rob_head_i,
  input  logic [NUM_ALU-1:0]                    req_valid_i,
  output logic [NUM_ALU-1:0]                    req_ready_o,
  input  logic [NUM_ALU*XLEN-1:0]               rs1_i,
  input  logic [NUM_ALU*XLEN-1:0]               rs2_i,
  input  logic [NUM_ALU*IMM_LEN-1:0]            imm_i,
  input  logic [NUM_ALU*2-1:0]                  opr1_sel_i,
  input  logic [NUM_ALU*2-1:0]                  opr2_sel_i,
  input  logic [NUM_ALU*3-1:0]                  func3_i,
  input  logic [NUM_ALU-1:0]                    func_mod_i,
  input  logic [NUM_ALU-1:0]                    half_i,
  input  logic [NUM_ALU-1:0]                    is_branch_i,
  input  logic [NUM_ALU-1:0]                    is_jump_i,
  input  logic [NUM_ALU*PC_WIDTH-1:0]           pc_i,
  input  logic [NUM_ALU*PC_WIDTH-1:0]           next_pc_i,
  input  logic [NUM_ALU*PC_WIDTH-1:0]           predict_pc_i,
  input  logic [NUM_ALU*ROB_INDEX_WIDTH-1:0]    rob_index_i,
  input  logic [NUM_ALU*PHY_REG_ADDR_WIDTH-1:0] prd_addr_i,
  output logic [NUM_ALU-1:0]                    resp_valid_o,
  input  logic [NUM_ALU-1:0]                    resp_ready_i,
  output logic [NUM_ALU*ROB_INDEX_WIDTH-1:0]    wrb_rob_index_o,
  output logic [NUM_ALU*PHY_REG_ADDR_WIDTH-1:0] wrb_prd_addr_o,
  output logic [NUM_ALU*XLEN-1:0]               wrb_data_o,
  output logic [NUM_ALU-1:0]                    branch_taken_o,
  output logic [NUM_ALU-1:0]                    predict_miss_o,
  output logic [NUM_ALU*PC_WIDTH-1:0]           final_next_pc_o,
  output logic                                  redirect_valid_o,
  output logic [PC_WIDTH-1:0]                   redirect_pc_o,
  output logic [ROB_INDEX_WIDTH-1:0]            redirect_rob_index_o
`ifdef FU_PERF_CNT_EN
  ,
  output logic [31:0]                           perf_issue_cnt_o,
  output logic [31:0]                           perf_miss_cnt_o
`endif
);

  localparam int unsigned RIW = ROB_INDEX_WIDTH;
  localparam int unsigned PCW = PC_WIDTH;

  logic [NUM_ALU-1:0] lane_cand;

  for (genvar i = 0; i < NUM_ALU; i++) begin : g_lane
    fu_alu_cluster_lane #(
      .XLEN               (XLEN),
      .PC_WIDTH           (PC_WIDTH),
      .IMM_LEN            (IMM_LEN),
      .ROB_INDEX_WIDTH    (ROB_INDEX_WIDTH),
      .PHY_REG_ADDR_WIDTH (PHY_REG_ADDR_WIDTH)
    ) u_lane (
      .clk               (clk),
      .rstn              (rstn),
      .flush_i           (flush_i),
      .req_valid_i       (req_valid_i[i]),
      .req_ready_o       (req_ready_o[i]),
      .rs1_i             (rs1_i[i*XLEN +: XLEN]),
      .rs2_i             (rs2_i[i*XLEN +: XLEN]),
      .imm_i             (imm_i[i*IMM_LEN +: IMM_LEN]),
      .opr1_sel_i        (opr1_sel_i[i*2 +: 2]),
      .opr2_sel_i        (opr2_sel_i[i*2 +: 2]),
      .func3_i           (func3_i[i*3 +: 3]),
      .func_mod_i        (func_mod_i[i]),
      .half_i            (half_i[i]),
      .is_branch_i       (is_branch_i[i]),
      .is_jump_i         (is_jump_i[i]),
      .pc_i              (pc_i[i*PCW +: PCW]),
      .next_pc_i         (next_pc_i[i*PCW +: PCW]),
      .predict_pc_i      (predict_pc_i[i*PCW +: PCW]),
      .rob_index_i       (rob_index_i[i*RIW +: RIW]),
      .prd_addr_i        (prd_addr_i[i*PHY_REG_ADDR_WIDTH +: PHY_REG_ADDR_WIDTH]),
      .resp_valid_o      (resp_valid_o[i]),
      .resp_ready_i      (resp_ready_i[i]),
      .wrb_rob_index_o   (wrb_rob_index_o[i*RIW +: RIW]),
      .wrb_prd_addr_o    (wrb_prd_addr_o[i*PHY_REG_ADDR_WIDTH +: PHY_REG_ADDR_WIDTH]),
      .wrb_data_o        (wrb_data_o[i*XLEN +: XLEN]),
      .branch_taken_o    (branch_taken_o[i]),
      .predict_miss_o    (predict_miss_o[i]),
      .final_next_pc_o   (final_next_pc_o[i*PCW +: PCW]),
      .redirect_cand_c_o (lane_cand[i])
    );
  end

  // Oldest mispredict wins; age is the ROB distance from head, modulo 2^RIW
  logic           found;
  logic [RIW-1:0] age, best_age, best_rob;
  logic [PCW-1:0] best_pc;

  always_comb begin
    found    = 1'b0;
    age      = '0;
    best_age = '0;
    best_rob = '0;
    best_pc  = '0;
    for (int i = 0; i < NUM_ALU; i++) begin
      age = wrb_rob_index_o[i*RIW +: RIW] - rob_head_i;
      if (lane_cand[i] && (!found || (age < best_age))) begin
        found    = 1'b1;
        best_age = age;
        best_rob = wrb_rob_index_o[i*RIW +: RIW];
        best_pc  = final_next_pc_o[i*PCW +: PCW];
      end
    end
  end

  assign redirect_valid_o     = found & ~flush_i;
  assign redirect_pc_o        = best_pc;
  assign redirect_rob_index_o = best_rob;

`ifdef FU_PERF_CNT_EN
  logic [NUM_ALU-1:0] req_fire;
  logic [31:0]        issue_inc;
  logic [32:0]        issue_sum;
  logic [31:0]        issue_cnt_q, issue_cnt_d, miss_cnt_q, miss_cnt_d;

  assign req_fire = req_valid_i & req_ready_o & {NUM_ALU{~flush_i}};

  // Issue count saturates; redirect count wraps. Neither is touched by flush.
  always_comb begin
    issue_inc = '0;
    for (int i = 0; i < NUM_ALU; i++) begin
      issue_inc = issue_inc + 32'(req_fire[i]);
    end
    issue_sum   = {1'b0, issue_cnt_q} + {1'b0, issue_inc};
    issue_cnt_d = issue_sum[32] ? '1 : issue_sum[31:0];
    miss_cnt_d  = miss_cnt_q + 32'(redirect_valid_o);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      issue_cnt_q <= '0;
      miss_cnt_q  <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign perf_issue_cnt_o = issue_cnt_q;
  assign perf_miss_cnt_o  = miss_cnt_q;
`else
  // Build without perf counters: no extra state or ports.
`endif

endmodule

// File: tb/tb_fu_alu_cluster.sv
// Directed self-checking bench for fu_alu_cluster (default 2-lane configuration).
module tb_fu_alu_cluster;

  localparam logic [1:0] SEL_REG = 2'd0, SEL_IMM = 2'd1, SEL_PC = 2'd2;

  logic          clk = 1'b0;
  logic          rstn;
  logic          flush;
  logic [3:0]    rob_head;
  logic [1:0]    req_valid, req_ready;
  logic [127:0]  rs1, rs2;
  logic [63:0]   imm;
  logic [3:0]    opr1_sel, opr2_sel;
  logic [5:0]    func3;
  logic [1:0]    func_mod, half, is_branch, is_jump;
  logic [63:0]   pc, next_pc, predict_pc;
  logic [7:0]    rob_index;
  logic [11:0]   prd_addr;
  logic [1:0]    resp_valid, resp_ready;
  logic [7:0]    wrb_rob;
  logic [11:0]   wrb_prd;
  logic [127:0]  wrb_data;
  logic [1:0]    taken, miss;
  logic [63:0]   final_npc;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic [3:0]    redirect_rob;
`ifdef FU_PERF_CNT_EN
  logic [31:0]   perf_issue_cnt, perf_miss_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fu_alu_cluster dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .flush_i              (flush),
    .rob_head_i           (rob_head),
    .req_valid_i          (req_valid),
    .req_ready_o          (req_ready),
    .rs1_i                (rs1),
    .rs2_i                (rs2),
    .imm_i                (imm),
    .opr1_sel_i           (opr1_sel),
    .opr2_sel_i           (opr2_sel),
    .func3_i              (func3),
    .func_mod_i           (func_mod),
    .half_i               (half),
    .is_branch_i          (is_branch),
    .is_jump_i            (is_jump),
    .pc_i                 (pc),
    .next_pc_i            (next_pc),
    .predict_pc_i         (predict_pc),
    .rob_index_i          (rob_index),
    .prd_addr_i           (prd_addr),
    .resp_valid_o         (resp_valid),
    .resp_ready_i         (resp_ready),
    .wrb_rob_index_o      (wrb_rob),
    .wrb_prd_addr_o       (wrb_prd),
    .wrb_data_o           (wrb_data),
    .branch_taken_o       (taken),
    .predict_miss_o       (miss),
    .final_next_pc_o      (final_npc),
    .redirect_valid_o     (redirect_valid),
    .redirect_pc_o        (redirect_pc),
    .redirect_rob_index_o (redirect_rob)
`ifdef FU_PERF_CNT_EN
    ,
    .perf_issue_cnt_o     (perf_issue_cnt),
    .perf_miss_cnt_o      (perf_miss_cnt)
`endif
  );

  task automatic clear_reqs();
    req_valid = '0; rs1 = '0; rs2 = '0; imm = '0; opr1_sel = '0; opr2_sel = '0;
    func3 = '0; func_mod = '0; half = '0; is_branch = '0; is_jump = '0;
    pc = '0; next_pc = '0; predict_pc = '0; rob_index = '0; prd_addr = '0;
  endtask

  task automatic set_req(input int l, input logic [63:0] a, input logic [63:0] b,
                         input logic [31:0] im, input logic [1:0] s1, input logic [1:0] s2,
                         input logic [2:0] f3, input logic md, input logic hf,
                         input logic br, input logic jp, input logic [31:0] p,
                         input logic [31:0] np, input logic [31:0] pp,
                         input logic [3:0] rb, input logic [5:0] pr);
    req_valid[l] = 1'b1;
    rs1[l*64 +: 64] = a;         rs2[l*64 +: 64] = b;
    imm[l*32 +: 32] = im;
    opr1_sel[l*2 +: 2] = s1;     opr2_sel[l*2 +: 2] = s2;
    func3[l*3 +: 3] = f3;        func_mod[l] = md;  half[l] = hf;
    is_branch[l] = br;           is_jump[l] = jp;
    pc[l*32 +: 32] = p;          next_pc[l*32 +: 32] = np;
    predict_pc[l*32 +: 32] = pp;
    rob_index[l*4 +: 4] = rb;    prd_addr[l*6 +: 6] = pr;
  endtask

  task automatic test_reset();
    rstn = 1'b0; flush = 1'b0; rob_head = '0; resp_ready = 2'b11;
    clear_reqs();
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (resp_valid !== 2'b00) begin n_err++; $display("FAIL reset_resp_valid: got %b expected 00", resp_valid); end
    n_cmp++; if (wrb_data !== 128'd0) begin n_err++; $display("FAIL reset_wrb_data: got %h expected 0", wrb_data); end
    n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL reset_redirect: got %b expected 0", redirect_valid); end
    n_cmp++; if (req_ready !== 2'b11) begin n_err++; $display("FAIL reset_req_ready: got %b expected 11", req_ready); end
    n_cmp++; if (final_npc !== 64'd0) begin n_err++; $display("FAIL reset_final_npc: got %h expected 0", final_npc); end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_addi();
    @(negedge clk);
    set_req(0, 64'd5, 64'd0, 32'hFFFF_FFFD, SEL_REG, SEL_IMM, 3'd0, 0, 0, 0, 0, 0, 0, 0, 4'd2, 6'd3);
    @(negedge clk);
    clear_reqs();
    #1;
    n_cmp++; if (resp_valid[0] !== 1'b1) begin n_err++; $display("FAIL addi_valid: got %b expected 1", resp_valid[0]); end
    n_cmp++; if (wrb_data[63:0] !== 64'd2) begin n_err++; $display("FAIL addi_data: got %h expected 2", wrb_data[63:0]); end
    n_cmp++; if (wrb_prd[5:0] !== 6'd3) begin n_err++; $display("FAIL addi_prd: got %0d expected 3", wrb_prd[5:0]); end
    n_cmp++; if (wrb_rob[3:0] !== 4'd2) begin n_err++; $display("FAIL addi_rob: got %0d expected 2", wrb_rob[3:0]); end
    n_cmp++; if (miss[0] !== 1'b0 || taken[0] !== 1'b0) begin n_err++; $display("FAIL addi_cf_flags: got taken=%b miss=%b expected 0 0", taken[0], miss[0]); end
    @(negedge clk);
    #1;
    n_cmp++; if (resp_valid[0] !== 1'b0) begin n_err++; $display("FAIL addi_drain: got %b expected 0", resp_valid[0]); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    resp_ready = 2'b00;
    set_req(0, 64'd10, 64'd20, 0, SEL_REG, SEL_REG, 3'd0, 0, 0, 0, 0, 0, 0, 0, 4'd4, 6'd7);
    @(negedge clk);
    set_req(0, 64'd1, 64'd1, 0, SEL_REG, SEL_REG, 3'd0, 0, 0, 0, 0, 0, 0, 0, 4'd5, 6'd8);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (req_ready[0] !== 1'b0) begin n_err++; $display("FAIL bp_ready_cyc%0d: got %b expected 0", k, req_ready[0]); end
      n_cmp++; if (resp_valid[0] !== 1'b1 || wrb_data[63:0] !== 64'd30 || wrb_prd[5:0] !== 6'd7)
        begin n_err++; $display("FAIL bp_hold_cyc%0d: got v=%b d=%h prd=%0d expected 1 30 7", k, resp_valid[0], wrb_data[63:0], wrb_prd[5:0]); end
      @(negedge clk);
    end
    resp_ready = 2'b11;
    #1;
    n_cmp++; if (req_ready[0] !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b expected 1", req_ready[0]); end
    @(negedge clk);
    clear_reqs();
    #1;
    n_cmp++; if (resp_valid[0] !== 1'b1 || wrb_data[63:0] !== 64'd2 || wrb_prd[5:0] !== 6'd8)
      begin n_err++; $display("FAIL bp_next_loaded: got v=%b d=%h prd=%0d expected 1 2 8", resp_valid[0], wrb_data[63:0], wrb_prd[5:0]); end
    @(negedge clk);
    #1;
    n_cmp++; if (resp_valid[0] !== 1'b0) begin n_err++; $display("FAIL bp_drain: got %b expected 0", resp_valid[0]); end
  endtask

  task automatic test_branch();
    @(negedge clk);
    resp_ready = 2'b00;
    set_req(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 32'h20, SEL_PC, SEL_IMM, 3'd4, 0, 0, 1, 0,
            32'h100, 32'h104, 32'h104, 4'd3, 6'd0);
    @(negedge clk);
    clear_reqs();
    #1;
    n_cmp++; if (taken[0] !== 1'b1) begin n_err++; $display("FAIL blt_taken: got %b expected 1", taken[0]); end
    n_cmp++; if (final_npc[31:0] !== 32'h120) begin n_err++; $display("FAIL blt_final_pc: got %h expected 120", final_npc[31:0]); end
    n_cmp++; if (miss[0] !== 1'b1) begin n_err++; $display("FAIL blt_miss: got %b expected 1", miss[0]); end
    n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL blt_redirect_held: got %b expected 0", redirect_valid); end
    @(negedge clk);
    resp_ready = 2'b11;
    #1;
    n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h120 || redirect_rob !== 4'd3)
      begin n_err++; $display("FAIL blt_redirect: got v=%b pc=%h rob=%0d expected 1 120 3", redirect_valid, redirect_pc, redirect_rob); end
    @(negedge clk);
    #1;
    n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL blt_redirect_once: got %b expected 0", redirect_valid); end
    set_req(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 32'h20, SEL_PC, SEL_IMM, 3'd5, 0, 0, 1, 0,
            32'h100, 32'h104, 32'h104, 4'd6, 6'd0);
    @(negedge clk);
    clear_reqs();
    #1;
    n_cmp++; if (taken[0] !== 1'b0 || miss[0] !== 1'b0 || final_npc[31:0] !== 32'h104)
      begin n_err++; $display("FAIL bge_not_taken: got t=%b m=%b pc=%h expected 0 0 104", taken[0], miss[0], final_npc[31:0]); end
    n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL bge_no_redirect: got %b expected 0", redirect_valid); end
    @(negedge clk);
  endtask

  task automatic test_age();
    @(negedge clk);
    resp_ready = 2'b00;
    rob_head = 4'd14;
    set_req(0, 64'd1, 64'd1, 32'h40, SEL_PC, SEL_IMM, 3'd0, 0, 0, 1, 0, 32'h200, 32'h204, 32'h204, 4'd1, 6'd0);
    set_req(1, 64'd7, 64'd7, 32'h10, SEL_PC, SEL_IMM, 3'd0, 0, 0, 1, 0, 32'h300, 32'h304, 32'h304, 4'd15, 6'd0);
    @(negedge clk);
    clear_reqs();
    resp_ready = 2'b11;
    #1;
    n_cmp++; if (miss !== 2'b11) begin n_err++; $display("FAIL age_miss: got %b expected 11", miss); end
    n_cmp++; if (redirect_valid !== 1'b1 || redirect_rob !== 4'd15 || redirect_pc !== 32'h310)
      begin n_err++; $display("FAIL age_wrap: got v=%b rob=%0d pc=%h expected 1 15 310", redirect_valid, redirect_rob, redirect_pc); end
    rob_head = 4'd0;
    #1;
    n_cmp++; if (redirect_rob !== 4'd1 || redirect_pc !== 32'h240)
      begin n_err++; $display("FAIL age_nowrap: got rob=%0d pc=%h expected 1 240", redirect_rob, redirect_pc); end
    @(negedge clk);
    #1;
    n_cmp++; if (resp_valid !== 2'b00 || redirect_valid !== 1'b0)
      begin n_err++; $display("FAIL age_drain: got v=%b rv=%b expected 00 0", resp_valid, redirect_valid); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    resp_ready = 2'b00;
    set_req(0, 64'd1, 64'd1, 32'h40, SEL_PC, SEL_IMM, 3'd0, 0, 0, 1, 0, 32'h200, 32'h204, 32'h204, 4'd1, 6'd0);
    set_req(1, 64'd7, 64'd7, 32'h10, SEL_PC, SEL_IMM, 3'd0, 0, 0, 1, 0, 32'h300, 32'h304, 32'h304, 4'd2, 6'd0);
    @(negedge clk);
    clear_reqs();
    flush = 1'b1;
    resp_ready = 2'b11;
    set_req(0, 64'd3, 64'd4, 0, SEL_REG, SEL_REG, 3'd0, 0, 0, 0, 0, 0, 0, 0, 4'd3, 6'd1);
    set_req(1, 64'd5, 64'd6, 0, SEL_REG, SEL_REG, 3'd0, 0, 0, 0, 0, 0, 0, 0, 4'd4, 6'd2);
    #1;
    n_cmp++; if (miss !== 2'b11) begin n_err++; $display("FAIL flush_pre_miss: got %b expected 11", miss); end
    n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL flush_redirect_gated: got %b expected 0", redirect_valid); end
    @(negedge clk);
    flush = 1'b0;
    clear_reqs();
    #1;
    n_cmp++; if (resp_valid !== 2'b00) begin n_err++; $display("FAIL flush_killed: got %b expected 00", resp_valid); end
    n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_redirect: got %b expected 0", redirect_valid); end
    @(negedge clk);
    #1;
    n_cmp++; if (resp_valid !== 2'b00) begin n_err++; $display("FAIL flush_nothing_loaded: got %b expected 00", resp_valid); end
  endtask

  task automatic test_half_jump();
    @(negedge clk);
    set_req(1, 64'h7FFF_FFFF, 64'd0, 32'd1, SEL_REG, SEL_IMM, 3'd0, 0, 1, 0, 0, 0, 0, 0, 4'd7, 6'd9);
    set_req(0, 64'h203, 64'd0, 32'd0, SEL_REG, SEL_IMM, 3'd0, 0, 0, 0, 1, 32'h50, 32'h54, 32'h202, 4'd8, 6'd10);
    @(negedge clk);
    clear_reqs();
    #1;
    n_cmp++; if (wrb_data[127:64] !== 64'hFFFF_FFFF_8000_0000) begin n_err++; $display("FAIL addw_data: got %h expected ffffffff80000000", wrb_data[127:64]); end
    n_cmp++; if (final_npc[31:0] !== 32'h202 || taken[0] !== 1'b1) begin n_err++; $display("FAIL jalr_target: got pc=%h t=%b expected 202 1", final_npc[31:0], taken[0]); end
    n_cmp++; if (wrb_data[63:0] !== 64'h54) begin n_err++; $display("FAIL jalr_link: got %h expected 54", wrb_data[63:0]); end
    n_cmp++; if (miss[0] !== 1'b0 || redirect_valid !== 1'b0) begin n_err++; $display("FAIL jalr_predicted: got m=%b rv=%b expected 0 0", miss[0], redirect_valid); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [63:0] va [14];
    logic [63:0] vb [14];
    logic [63:0] vx [14];
    logic [2:0]  vf [14];
    logic        vm [14];
    logic        vh [14];
    va = '{64'd5, 64'd1, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hF0, 64'h8000_0000_0000_0000,
           64'h8000_0000_0000_0000, 64'hF0, 64'hF0, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000, 64'd0, 64'd1};
    vb = '{64'd7, 64'd63, 64'd63, 64'd1, 64'd1, 64'hFF, 64'd4, 64'd4, 64'h0F, 64'h3C, 64'd4, 64'd4, 64'd1, 64'd65};
    vf = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7, 3'd5, 3'd5, 3'd0, 3'd1};
    vm = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vh = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vx = '{64'hFFFF_FFFF_FFFF_FFFE, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000, 64'd1, 64'd0, 64'h0F,
           64'h0800_0000_0000_0000, 64'hF800_0000_0000_0000, 64'hFF, 64'h30, 64'hFFFF_FFFF_F800_0000,
           64'h0000_0000_0800_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2};
    resp_ready = 2'b11;
    for (int i = 0; i <= 14; i++) begin
      @(negedge clk);
      if (i > 0) begin
        #1;
        n_cmp++; if (resp_valid[0] !== 1'b1 || wrb_data[63:0] !== vx[i-1])
          begin n_err++; $display("FAIL b2b_op%0d: got v=%b d=%h expected 1 %h", i-1, resp_valid[0], wrb_data[63:0], vx[i-1]); end
      end
      if (i < 14) set_req(0, va[i], vb[i], 0, SEL_REG, SEL_REG, vf[i], vm[i], vh[i], 0, 0, 0, 0, 0, 4'(i), 6'(i));
      else clear_reqs();
    end
    @(negedge clk);
    #1;
    n_cmp++; if (resp_valid[0] !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %b expected 0", resp_valid[0]); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_backpressure();
    test_branch();
    test_age();
    test_flush();
    test_half_jump();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
